// File: rtl/s2p_window_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : s2p_window_packer_pkg
// Brief    : Shared defaults and FSM encoding for the serial-to-parallel packer.
// Revision : 1.0
// ============================================================================
package s2p_window_packer_pkg;

  localparam int unsigned c_DATA_WIDTH = 8;
  localparam int unsigned c_S2P_SIZE   = 3;
  localparam int unsigned c_NUM_CH     = 2;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_PAD   = 2'd1,
    ST_STALL = 2'd2
  } state_e;

  function automatic int unsigned win_elems(input int unsigned side);
    return side * side;
  endfunction

endpackage
`default_nettype wire

// File: rtl/s2p_window_packer_lane.sv
`default_nettype none
// ============================================================================
// Module   : s2p_lane
// Brief    : One lane's N-deep shift register with pad masking; snap_o is the
//            window as it will look after the current shift.
// Revision : 1.0
// ============================================================================
module s2p_lane
  import s2p_window_packer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = c_DATA_WIDTH,
  parameter int unsigned N          = c_S2P_SIZE * c_S2P_SIZE
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    shift_i,
  input  logic                    pad_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  output logic [N*DATA_WIDTH-1:0] win_o,
  output logic [N*DATA_WIDTH-1:0] snap_o
);

  logic [N*DATA_WIDTH-1:0] win_q;
  logic [DATA_WIDTH-1:0]   w_elem;

  assign w_elem = pad_i ? '0 : data_i;
  // Element 0 is the newest beat, so older elements move toward the top.
  assign snap_o = {win_q[(N-1)*DATA_WIDTH-1:0], w_elem};
  assign win_o  = win_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      win_q <= '0;
    end else if (shift_i) begin
      win_q <= snap_o;
    end
  end

endmodule
`default_nettype wire

// File: rtl/s2p_window_packer.sv
`default_nettype none
// ============================================================================
// Module   : s2p_window_packer
// Brief    : Packs NUM_CH serial lanes into S2P_SIZE x S2P_SIZE windows with
//            end-of-frame zero padding and a single registered output slot.
// Revision : 1.0
// ============================================================================
module s2p_window_packer
  import s2p_window_packer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = c_DATA_WIDTH,
  parameter int unsigned S2P_SIZE   = c_S2P_SIZE,
  parameter int unsigned NUM_CH     = c_NUM_CH
) (
  input  logic                                                clk,
  input  logic                                                rstn,
  input  logic                                                i_valid,
  output logic                                                o_in_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0]                        i_data,
  input  logic [NUM_CH-1:0]                                   i_pad,
  input  logic                                                i_last,
  output logic [NUM_CH*S2P_SIZE*S2P_SIZE*DATA_WIDTH-1:0]      o_matrix,
  output logic                                                o_valid,
  input  logic                                                i_out_ready,
  output logic                                                o_last
);

  localparam int unsigned           c_N        = win_elems(S2P_SIZE);
  localparam int unsigned           c_CNT_W    = $clog2(c_N);
  localparam logic [c_CNT_W-1:0]    c_CNT_LAST = c_CNT_W'(c_N - 1);
  localparam int unsigned           c_LANE_W   = c_N * DATA_WIDTH;

  state_e                     state_q, state_d;
  logic [c_CNT_W-1:0]         cnt_q, cnt_d;
  logic                       valid_q, valid_d;
  logic                       last_q, last_d;
  logic                       pend_last_q, pend_last_d;
  logic [NUM_CH*c_LANE_W-1:0] matrix_q, matrix_d;
  logic [NUM_CH*c_LANE_W-1:0] w_win, w_snap;

  logic w_in_ready, w_pad_cycle, w_stall;
  logic w_shift, w_cnt_end, w_complete, w_slot_free, w_load, w_complete_last;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM outputs
  always_comb begin
    w_in_ready  = 1'b0;
    w_pad_cycle = 1'b0;
    w_stall     = 1'b0;
    case (state_q)
      ST_FILL:  w_in_ready  = 1'b1;
      ST_PAD:   w_pad_cycle = 1'b1;
      ST_STALL: w_stall     = 1'b1;
      default:  w_in_ready  = 1'b1;
    endcase
  end

  assign w_shift         = (i_valid & w_in_ready) | w_pad_cycle;
  assign w_cnt_end       = (cnt_q == c_CNT_LAST);
  assign w_complete      = w_shift & w_cnt_end;
  assign w_slot_free     = ~valid_q | i_out_ready;
  assign w_complete_last = w_pad_cycle | i_last;
  assign w_load          = (w_complete & w_slot_free) | (w_stall & i_out_ready);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL: begin
        if (w_shift) begin
          if (w_cnt_end) begin
            state_d = w_slot_free ? ST_FILL : ST_STALL;
          end else if (i_last) begin
            state_d = ST_PAD;
          end
        end
      end
      ST_PAD: begin
        if (w_cnt_end) begin
          state_d = w_slot_free ? ST_FILL : ST_STALL;
        end
      end
      ST_STALL: begin
        if (i_out_ready) begin
          state_d = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  // A completing cycle loads the post-shift snapshot; a stalled window
  // already sits in the lane registers.
  always_comb begin
    cnt_d       = cnt_q;
    pend_last_d = pend_last_q;
    matrix_d    = matrix_q;
    last_d      = last_q;
    valid_d     = valid_q & ~i_out_ready;
    if (w_shift) begin
      cnt_d = w_cnt_end ? '0 : cnt_q + 1'b1;
    end
    if (w_complete) begin
      pend_last_d = w_complete_last;
    end
    if (w_load) begin
      valid_d = 1'b1;
      if (w_complete) begin
        matrix_d = w_snap;
        last_d   = w_complete_last;
      end else begin
        matrix_d = w_win;
        last_d   = pend_last_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q       <= '0;
      pend_last_q <= 1'b0;
      matrix_q    <= '0;
      last_q      <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      pend_last_q <= pend_last_d;
      matrix_q    <= matrix_d;
      last_q      <= last_d;
      valid_q     <= valid_d;
    end
  end

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
      s2p_lane #(
        .DATA_WIDTH (DATA_WIDTH),
        .N          (c_N)
      ) u_lane (
        .clk     (clk),
        .rstn    (rstn),
        .shift_i (w_shift),
        .pad_i   (w_pad_cycle | i_pad[c]),
        .data_i  (i_data[c*DATA_WIDTH +: DATA_WIDTH]),
        .win_o   (w_win[c*c_LANE_W +: c_LANE_W]),
        .snap_o  (w_snap[c*c_LANE_W +: c_LANE_W])
      );
    end
  endgenerate

  assign o_in_ready = w_in_ready;
  assign o_matrix   = matrix_q;
  assign o_valid    = valid_q;
  assign o_last     = last_q;

endmodule
`default_nettype wire

// File: tb/tb_s2p_window_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_s2p_window_packer
// Brief    : Self-checking bench: frame table plus hand-written corner cases,
//            windows checked against a scoreboard queue.
// Revision : 1.0
// ============================================================================
module tb_s2p_window_packer;

  localparam int DW = 8;
  localparam int S  = 3;
  localparam int N  = S * S;
  localparam int NC = 2;
  localparam int MW = NC * N * DW;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           i_valid = 1'b0;
  logic           i_last = 1'b0;
  logic           i_out_ready = 1'b1;
  logic [NC*DW-1:0] i_data = '0;
  logic [NC-1:0]  i_pad = '0;
  logic           o_in_ready, o_valid, o_last;
  logic [MW-1:0]  o_matrix;

  s2p_window_packer #(
    .DATA_WIDTH (DW),
    .S2P_SIZE   (S),
    .NUM_CH     (NC)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .i_valid     (i_valid),
    .o_in_ready  (o_in_ready),
    .i_data      (i_data),
    .i_pad       (i_pad),
    .i_last      (i_last),
    .o_matrix    (o_matrix),
    .o_valid     (o_valid),
    .i_out_ready (i_out_ready),
    .o_last      (o_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [MW-1:0] m;
    logic          l;
  } exp_t;

  typedef struct {
    int         nb;
    logic       last;
    logic [7:0] b0;
    logic [7:0] b1;
    int         plo;
    int         phi;
    logic [1:0] pm;
  } vec_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  // Element k holds beat N-k (1-based); beats never sent, or padded, are 0.
  function automatic logic [MW-1:0] exp_window(input int nb, input logic [7:0] b0,
                                                input logic [7:0] b1, input int plo,
                                                input int phi, input logic [1:0] pm);
    logic [MW-1:0] m;
    logic [DW-1:0] v;
    int            beat;
    m = '0;
    for (int c = 0; c < NC; c++) begin
      for (int k = 0; k < N; k++) begin
        beat = N - k;
        v = '0;
        if (beat <= nb && !(pm[c] && beat >= plo && beat <= phi))
          v = ((c == 0) ? b0 : b1) + DW'(beat - 1);
        m[(c*N+k)*DW +: DW] = v;
      end
    end
    return m;
  endfunction

  function automatic logic [NC*DW-1:0] beat_data(input logic [7:0] b0, input logic [7:0] b1, input int j);
    return {b1 + DW'(j - 1), b0 + DW'(j - 1)};
  endfunction

  function automatic logic [1:0] beat_pad(input int plo, input int phi, input logic [1:0] pm, input int j);
    return (j >= plo && j <= phi) ? pm : 2'b00;
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_beat(input logic [NC*DW-1:0] d, input logic [1:0] p, input logic l);
    int w;
    w = 0;
    while (!o_in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (!o_in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL in_ready_timeout: got o_in_ready=0 required 1 within 50 cycles");
    end
    i_valid = 1'b1;
    i_data  = d;
    i_pad   = p;
    i_last  = l;
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_pad   = '0;
  endtask

  task automatic send_frame(input vec_t v);
    exp_t e;
    for (int j = 1; j <= v.nb; j++) begin
      if (j == v.nb) begin
        e.m = exp_window(v.nb, v.b0, v.b1, v.plo, v.phi, v.pm);
        e.l = v.last;
        sb.push_back(e);
      end
      send_beat(beat_data(v.b0, v.b1, j), beat_pad(v.plo, v.phi, v.pm, j), (j == v.nb) && v.last);
    end
  endtask

  task automatic wait_empty();
    int w;
    w = 0;
    i_out_ready = 1'b1;
    while (sb.size() != 0 && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d pending windows required 0", sb.size());
      sb.delete();
    end
  endtask

  // Scoreboard: every window taken by the consumer is checked in order.
  always @(negedge clk) begin
    if (rstn && o_valid && i_out_ready) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_window: got o_valid=1 required no pending window");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("window", o_matrix, e.m);
        chk1("window_last", o_last, e.l);
      end
    end
  end

  initial begin
    vec_t          tbl[7];
    vec_t          v;
    logic [MW-1:0] exp_a, exp_b;
    exp_t          e;

    tbl[0] = '{9, 1'b0, 8'h01, 8'h11, 0, 0, 2'b00};
    tbl[1] = '{9, 1'b0, 8'h21, 8'h31, 3, 4, 2'b10};
    tbl[2] = '{4, 1'b1, 8'h01, 8'h41, 0, 0, 2'b00};
    tbl[3] = '{9, 1'b1, 8'h50, 8'hA0, 0, 0, 2'b00};
    tbl[4] = '{1, 1'b1, 8'hC3, 8'h3C, 0, 0, 2'b00};
    tbl[5] = '{9, 1'b0, 8'hE0, 8'hF0, 1, 9, 2'b01};
    tbl[6] = '{8, 1'b1, 8'h90, 8'h05, 2, 2, 2'b11};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk1("reset_valid", o_valid, 1'b0);
    chk1("reset_last", o_last, 1'b0);
    chk("reset_matrix", o_matrix, '0);
    chk1("reset_in_ready", o_in_ready, 1'b1);
    #2 rstn = 1'b1;
    @(posedge clk); #1;

    // Table-driven frames with the consumer always ready
    for (int i = 0; i < 7; i++) begin
      send_frame(tbl[i]);
      if (tbl[i].nb == N) chk1("valid_after_last_beat", o_valid, 1'b1);
    end
    wait_empty();

    // Partial frame: five pad cycles with input blocked
    v = '{4, 1'b1, 8'h0A, 8'h0B, 0, 0, 2'b00};
    send_frame(v);
    for (int i = 0; i < 5; i++) begin
      chk1("pad_in_ready", o_in_ready, 1'b0);
      @(posedge clk); #1;
    end
    chk1("pad_done_in_ready", o_in_ready, 1'b1);
    chk1("pad_done_valid", o_valid, 1'b1);
    chk1("pad_done_last", o_last, 1'b1);
    wait_empty();

    // Backpressure: 18 beats into a blocked slot, then a one-cycle pulse
    i_out_ready = 1'b0;
    exp_a = exp_window(9, 8'h60, 8'h70, 0, 0, 2'b00);
    exp_b = exp_window(9, 8'h80, 8'h90, 0, 0, 2'b00);
    send_frame('{9, 1'b0, 8'h60, 8'h70, 0, 0, 2'b00});
    send_frame('{9, 1'b0, 8'h80, 8'h90, 0, 0, 2'b00});
    chk1("stall_in_ready", o_in_ready, 1'b0);
    chk1("stall_valid", o_valid, 1'b1);
    chk("stall_matrix", o_matrix, exp_a);
    repeat (3) @(posedge clk);
    #1;
    chk("stall_hold_matrix", o_matrix, exp_a);
    chk1("stall_hold_in_ready", o_in_ready, 1'b0);
    i_out_ready = 1'b1;
    @(posedge clk); #1;
    i_out_ready = 1'b0;
    chk1("unstall_valid", o_valid, 1'b1);
    chk1("unstall_in_ready", o_in_ready, 1'b1);
    chk("unstall_matrix", o_matrix, exp_b);
    wait_empty();

    // Consumption and completion on the same edge
    i_out_ready = 1'b0;
    send_frame('{9, 1'b1, 8'h33, 8'h44, 0, 0, 2'b00});
    for (int j = 1; j <= 8; j++) send_beat(beat_data(8'hB0, 8'hD0, j), 2'b00, 1'b0);
    exp_b = exp_window(9, 8'hB0, 8'hD0, 0, 0, 2'b00);
    e.m = exp_b;
    e.l = 1'b0;
    sb.push_back(e);
    i_out_ready = 1'b1;
    send_beat(beat_data(8'hB0, 8'hD0, 9), 2'b00, 1'b0);
    chk1("simul_valid", o_valid, 1'b1);
    chk1("simul_in_ready", o_in_ready, 1'b1);
    chk("simul_matrix", o_matrix, exp_b);
    chk1("simul_last", o_last, 1'b0);
    wait_empty();

    // Reset mid-window with a pending window in the slot
    i_out_ready = 1'b0;
    send_frame('{9, 1'b0, 8'h10, 8'h20, 0, 0, 2'b00});
    for (int j = 1; j <= 5; j++) send_beat(beat_data(8'hF0, 8'h0F, j), 2'b00, 1'b0);
    #3 rstn = 1'b0;
    #1;
    chk1("midrst_valid", o_valid, 1'b0);
    chk1("midrst_last", o_last, 1'b0);
    chk("midrst_matrix", o_matrix, '0);
    chk1("midrst_in_ready", o_in_ready, 1'b1);
    sb.delete();
    @(posedge clk);
    #3 rstn = 1'b1;
    @(posedge clk); #1;
    i_out_ready = 1'b1;
    send_frame('{9, 1'b0, 8'h71, 8'h81, 0, 0, 2'b00});
    chk1("postrst_valid", o_valid, 1'b1);
    wait_empty();

    repeat (2) @(posedge clk);
    #1;
    chk1("idle_valid", o_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
